// File: rtl/clock_ui_pkg.sv
// Shared types and constants for the clock user-interface blocks:
// controller state, display page codes and edit-cursor limits.
package clock_ui_pkg;

    typedef enum logic [0:0] {
        VIEW = 1'b0,
        EDIT = 1'b1
    } uiState_t;

    localparam logic [1:0] DISP_TIME  = 2'd0;
    localparam logic [1:0] DISP_DATE  = 2'd1;
    localparam logic [1:0] DISP_ALARM = 2'd2;

    localparam logic [2:0] CUR_FIRST = 3'd5;
    localparam logic [2:0] CUR_LAST  = 3'd0;

    function automatic logic [1:0] nextDisp(input logic [1:0] disp);
        return (disp >= DISP_ALARM) ? DISP_TIME : disp + 2'd1;
    endfunction

    // Cursor walks from the seconds-units digit leftwards, then wraps.
    function automatic logic [2:0] nextCur(input logic [2:0] cur);
        return (cur == CUR_LAST) ? CUR_FIRST : cur - 3'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low board key: 2-flop synchronizer, stability counter and
// registered one-cycle press/release pulses derived from the debounced level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic keyRaw_n,
    output logic keyLevel,
    output logic pressPulse,
    output logic releasePulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          syncA;
    logic          syncB;
    logic          levelPrev;
    logic [CW-1:0] cntReg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            syncA        <= 1'b1;
            syncB        <= 1'b1;
            keyLevel     <= 1'b1;
            levelPrev    <= 1'b1;
            cntReg       <= '0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
        end else begin
            syncA        <= keyRaw_n;
            syncB        <= syncA;
            levelPrev    <= keyLevel;
            pressPulse   <= levelPrev & ~keyLevel;
            releasePulse <= ~levelPrev & keyLevel;
            // Any cycle where the synchronized value agrees restarts the count.
            if (syncB != keyLevel) begin
                if (cntReg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    keyLevel <= syncB;
                    cntReg   <= '0;
                end else begin
                    cntReg <= cntReg + 1'b1;
                end
            end else begin
                cntReg <= '0;
            end
        end
    end

endmodule

// File: rtl/edit_controller.sv
// Three-key clock UI controller: KEY3 short/long press handles page and edit
// navigation, KEY1/KEY2 issue increment/decrement pulses while editing.
module edit_controller
    import clock_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int LONG_CYCLES     = 1000,
    parameter int TIMEOUT_TICKS   = 10
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [2:0] KEY_n,
    input  logic       tick,
    output logic       editMode,
    output logic [2:0] editCur,
    output logic [1:0] disMode,
    output logic       incPulse,
    output logic       decPulse
);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [2:0] keyLevel;
    logic [2:0] keyPress;
    logic [2:0] keyRelease;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gKey
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) uKey (
                .Clk         (Clk),
                .Rst_n       (Rst_n),
                .keyRaw_n    (KEY_n[gi]),
                .keyLevel    (keyLevel[gi]),
                .pressPulse  (keyPress[gi]),
                .releasePulse(keyRelease[gi])
            );
        end
    endgenerate

    logic unusedKeys;
    assign unusedKeys = ^{keyLevel[1:0], keyRelease[1:0]};

    // Hold counter saturates, so a long press fires exactly once per hold and
    // its eventual release is not mistaken for a short press.
    logic [HW-1:0] holdReg;
    logic          longEvent;
    logic          shortEvent;

    assign longEvent  = !keyLevel[2] && (holdReg == HW'(LONG_CYCLES - 1));
    assign shortEvent = keyRelease[2] && (holdReg != HW'(LONG_CYCLES));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            holdReg <= '0;
        end else if (keyRelease[2]) begin
            holdReg <= '0;
        end else if (!keyLevel[2] && (holdReg != HW'(LONG_CYCLES))) begin
            holdReg <= holdReg + 1'b1;
        end
    end

    uiState_t      stateReg, stateNext;
    logic [TW-1:0] tmoReg, tmoNext;
    logic [2:0]    curNext;
    logic [1:0]    dispNext;
    logic          incNext, decNext;
    logic          keyEvent;

    assign keyEvent = |keyPress;
    assign editMode = (stateReg == EDIT);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateReg <= VIEW;
            tmoReg   <= '0;
            editCur  <= CUR_FIRST;
            disMode  <= DISP_TIME;
            incPulse <= 1'b0;
            decPulse <= 1'b0;
        end else begin
            stateReg <= stateNext;
            tmoReg   <= tmoNext;
            editCur  <= curNext;
            disMode  <= dispNext;
            incPulse <= incNext;
            decPulse <= decNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        tmoNext   = tmoReg;
        curNext   = editCur;
        dispNext  = disMode;
        incNext   = 1'b0;
        decNext   = 1'b0;
        case (stateReg)
            VIEW: begin
                tmoNext = '0;
                if (longEvent) begin
                    stateNext = EDIT;
                    curNext   = CUR_FIRST;
                end else if (shortEvent) begin
                    dispNext = nextDisp(disMode);
                end
            end
            EDIT: begin
                // Simultaneous up and down cancel each other but still count as activity.
                incNext = keyPress[0] & ~keyPress[1];
                decNext = keyPress[1] & ~keyPress[0];
                if (keyEvent) begin
                    tmoNext = '0;
                end else if (tick && (tmoReg != TW'(TIMEOUT_TICKS))) begin
                    tmoNext = tmoReg + 1'b1;
                end
                if ((tmoReg == TW'(TIMEOUT_TICKS)) || longEvent) begin
                    stateNext = VIEW;
                    curNext   = CUR_FIRST;
                    tmoNext   = '0;
                    incNext   = 1'b0;
                    decNext   = 1'b0;
                end else if (shortEvent) begin
                    curNext = nextCur(editCur);
                end
            end
            default: begin
                stateNext = VIEW;
            end
        endcase
    end

endmodule

// File: tb/tb_edit_controller.sv
// Directed bench for edit_controller with short debounce/hold/timeout settings;
// expected values are hand-derived cycle counts and UI state sequences.
module tb_edit_controller;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int TMO  = 10;

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic [2:0] KEY_n = 3'b111;
    logic       tick  = 1'b0;
    logic       editMode;
    logic [2:0] editCur;
    logic [1:0] disMode;
    logic       incPulse;
    logic       decPulse;

    int checks   = 0;
    int errors   = 0;
    int incCount = 0;
    int decCount = 0;

    always #5 Clk = ~Clk;

    edit_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .TIMEOUT_TICKS  (TMO)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .KEY_n   (KEY_n),
        .tick    (tick),
        .editMode(editMode),
        .editCur (editCur),
        .disMode (disMode),
        .incPulse(incPulse),
        .decPulse(decPulse)
    );

    always @(negedge Clk) begin
        if (incPulse) incCount++;
        if (decPulse) decCount++;
    end

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pressKey(input int idx, input int n);
        KEY_n[idx] = 1'b0;
        cyc(n);
        KEY_n[idx] = 1'b1;
        cyc(20);
    endtask

    task automatic doTick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(2);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_editMode"}, int'(editMode), 0);
        checkVal({tag, "_editCur"},  int'(editCur),  5);
        checkVal({tag, "_disMode"},  int'(disMode),  0);
        checkVal({tag, "_incPulse"}, int'(incPulse), 0);
        checkVal({tag, "_decPulse"}, int'(decPulse), 0);
    endtask

    initial begin
        int incBase;
        int decBase;
        int expDisp [4] = '{1, 2, 0, 1};
        int expCur  [3] = '{4, 3, 2};

        cyc(3);
        checkResetOutputs("reset");
        Rst_n = 1'b1;
        cyc(2);

        // Short KEY3 presses in VIEW cycle the display page.
        for (int i = 0; i < 4; i++) begin
            pressKey(2, 10);
            checkVal($sformatf("view_short%0d_disMode", i), int'(disMode), expDisp[i]);
            checkVal($sformatf("view_short%0d_editMode", i), int'(editMode), 0);
        end

        // Long press: debounce (DEB+2 edges) plus LONG debounced cycles.
        KEY_n[2] = 1'b0;
        cyc(25);
        checkVal("long_before", int'(editMode), 0);
        cyc(1);
        checkVal("long_enter_editMode", int'(editMode), 1);
        checkVal("long_enter_editCur", int'(editCur), 5);
        cyc(4);
        KEY_n[2] = 1'b1;
        cyc(20);
        checkVal("long_release_editMode", int'(editMode), 1);
        checkVal("long_release_editCur", int'(editCur), 5);
        checkVal("long_release_disMode", int'(disMode), 1);

        for (int i = 0; i < 3; i++) begin
            pressKey(2, 10);
            checkVal($sformatf("edit_short%0d_editCur", i), int'(editCur), expCur[i]);
        end
        checkVal("edit_disMode_frozen", int'(disMode), 1);
        checkVal("edit_editMode_kept", int'(editMode), 1);

        // KEY1 bounce then steady low: one incPulse, DEB+4 edges after last fall.
        incBase = incCount;
        KEY_n[0] = 1'b0;
        cyc(1);
        KEY_n[0] = 1'b1;
        cyc(1);
        KEY_n[0] = 1'b0;
        cyc(7);
        checkVal("inc_early", int'(incPulse), 0);
        cyc(1);
        checkVal("inc_on_time", int'(incPulse), 1);
        cyc(1);
        checkVal("inc_one_cycle", int'(incPulse), 0);
        cyc(10);
        checkVal("inc_bounce_count", incCount - incBase, 1);
        KEY_n[0] = 1'b1;
        cyc(15);

        incBase = incCount;
        decBase = decCount;
        KEY_n[1:0] = 2'b00;
        cyc(15);
        KEY_n[1:0] = 2'b11;
        cyc(15);
        checkVal("both_inc_count", incCount - incBase, 0);
        checkVal("both_dec_count", decCount - decBase, 0);

        decBase = decCount;
        pressKey(1, 10);
        checkVal("key2_dec_count", decCount - decBase, 1);
        checkVal("key2_editCur", int'(editCur), 2);

        // Asynchronous reset mid-edit and mid-hold, KEY3 kept low through it.
        KEY_n[2] = 1'b0;
        cyc(15);
        Rst_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        cyc(25);
        checkVal("post_reset_hold_before", int'(editMode), 0);
        cyc(1);
        checkVal("post_reset_hold_enter", int'(editMode), 1);
        cyc(4);
        KEY_n[2] = 1'b1;
        cyc(20);

        pressKey(2, 10);
        checkVal("tmo_setup_editCur", int'(editCur), 4);
        for (int i = 0; i < 9; i++) doTick();
        checkVal("tmo_tick9_editMode", int'(editMode), 1);
        doTick();
        checkVal("tmo_tick10_editMode", int'(editMode), 0);
        checkVal("tmo_tick10_editCur", int'(editCur), 5);

        pressKey(2, 30);
        checkVal("reenter_editMode", int'(editMode), 1);
        for (int i = 0; i < 8; i++) doTick();
        // KEY2 press event lands in the same cycle as tick 9.
        decBase = decCount;
        KEY_n[1] = 1'b0;
        cyc(7);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(2);
        KEY_n[1] = 1'b1;
        cyc(12);
        checkVal("tick_key_dec_count", decCount - decBase, 1);
        doTick();
        checkVal("tick_key_no_exit", int'(editMode), 1);
        for (int i = 0; i < 8; i++) doTick();
        checkVal("restart_tick9_editMode", int'(editMode), 1);
        doTick();
        checkVal("restart_tick10_editMode", int'(editMode), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
